poly_arith_ctrl: RTL and testbench
==================================

Name: poly_arith_ctrl

Overview:
- Sequencer for the coefficient-wise polynomial arithmetic path: modular multiply, add and subtract.
- On a start pulse it latches the opcode and polynomial indices. It then streams paired operand read addresses (A then B, every word) to the RAM, and drives valid_in, swap, opcode and addr to the arithmetic data shuffler.
- It counts write-backs returned from the shuffler and signals done once the destination polynomial is fully written.
- It sits between the top-level instruction decoder and the RAM/shuffler/BFU path, alongside the NTT controller.

Parameters:
- LOGN, 8, log2 of polynomial length N.
- PE, 4, butterfly units; each RAM word holds 2*PE coefficients.
- NUM_POLY, 4, polynomials resident in RAM.
- WB_TIMEOUT, 256, maximum cycles in DRAIN without a write-back before err is raised.
- Derived: WORDS = N/(2*PE). AW = clog2(NUM_POLY*WORDS). PW = max(1, clog2(NUM_POLY)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- op_in  in  2  1: modmult, 2: modadd, 3: modsub; 0 (NTT) is illegal here
- swap_in  in  1  bank-order select, latched at start
- src_a  in  PW  operand A polynomial index
- src_b  in  PW  operand B polynomial index
- dst  in  PW  destination polynomial index
- wb_valid  in  1  write-back strobe (shuffler valid_out)
- raddr  out  AW  RAM read address
- addr  out  AW  destination address to shuffler
- valid  out  1  shuffler valid_in
- swap  out  1  shuffler swap
- opcode  out  2  shuffler opcode
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse on completion
- err  out  1  one-cycle pulse: illegal op or write-back timeout

Behaviour:
- Reset: state IDLE. All counters 0. raddr, addr, opcode = 0; valid, swap, busy, done, err = 0. Reset in any state aborts immediately, with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE, start with op_in = 0: stay IDLE, err = 1 next cycle, busy stays 0.
- IDLE, start with op_in in {1,2,3}: latch op_in, swap_in, src_a, src_b, dst. Next cycle enter ISSUE with busy = 1.
- ISSUE spans exactly 2*WORDS cycles. Issue counter k runs 0..2*WORDS-1, with word index i = k>>1.
  - k even: raddr = src_a*WORDS + i.
  - k odd: raddr = src_b*WORDS + i.
  - addr = dst*WORDS + i, held for both cycles of the pair.
  - valid = 1 for all of ISSUE; the shuffler internally toggles to one write per pair.
  - opcode and swap are driven from the latched values throughout ISSUE and DRAIN, and return to 0 in IDLE.
- After the last ISSUE cycle (k = 2*WORDS-1): enter DRAIN with valid = 0, raddr and addr frozen.
- Write-back counter:
  - Increments on every wb_valid while busy, including during ISSUE.
  - wb_valid while not busy is ignored.
  - A wb_valid arriving after the count reaches WORDS is ignored.
- DRAIN exit to FIN: the cycle after the counter reaches WORDS.
- DRAIN timeout:
  - A cycle counter resets on each wb_valid.
  - If it reaches WB_TIMEOUT, err pulses for 1 cycle and the FSM goes to IDLE with busy = 0 and no done.
- FIN: done = 1 for exactly one cycle, busy = 0 in that same cycle. Next state IDLE.
- start while busy, or in FIN, is ignored; no queueing.
- Aliasing: src_a = src_b = dst is legal. The controller does no hazard checking; in-place correctness is guaranteed by the read-ahead of the pipeline.
- Address arithmetic is exact, with no wrap. Polynomial indices >= NUM_POLY are out of contract.
- Latency: done occurs 1 cycle after the WORDS-th wb_valid, provided ISSUE has completed. Minimum start-to-done is 2*WORDS + 2 cycles plus the pipeline latency of the path.

Test Plan:
- Example configuration for all scenarios: LOGN=4, PE=2, NUM_POLY=4, giving WORDS=4 and AW=4.
- Addition: start with op_in=2, src_a=1, src_b=2, dst=3.
  - raddr sequence 4,8,5,9,6,10,7,11.
  - addr sequence 12,12,13,13,14,14,15,15.
  - valid high for 8 cycles, opcode=2.
  - Model returns 4 wb_valid strobes with latency 6 → done pulses once, 1 cycle after the 4th strobe; busy falls in the same cycle.
- Illegal op: start with op_in=0 → err pulse 1 cycle later; busy, valid and done stay 0; raddr stays 0.
- Early write-backs: 4 wb_valid strobes all arrive during ISSUE → FSM passes through DRAIN for exactly 1 cycle, then FIN; done occurs 2 cycles after the last ISSUE cycle.
- Timeout: WB_TIMEOUT=16, only 3 wb_valid strobes returned → err pulses 16 cycles after the 3rd strobe; no done; next start is accepted normally.
- Reset mid-ISSUE: rst asserted at k=3 → the next cycle shows all outputs 0 and IDLE. A subsequent modmult with src_a=src_b=dst=0 runs raddr 0,0,1,1,2,2,3,3 with opcode=1.
- Protocol: start pulsed while busy and again in the FIN cycle → both ignored; a stray wb_valid in IDLE does not pre-load the counter, so the next operation still requires 4 strobes.

Source files
------------

// File: rtl/poly_arith_ctrl.sv
// Sequencer for coefficient-wise modmult/modadd/modsub over RAM-resident
// polynomials: streams A/B read pairs, tracks write-backs, reports done.
module poly_arith_ctrl #(
  parameter int LOGN = 8,
  parameter int PE = 4,
  parameter int NUM_POLY = 4,
  parameter int WB_TIMEOUT = 256,
  localparam int N = 1 << LOGN,
  localparam int WORDS = N / (2 * PE),
  localparam int AW = $clog2(NUM_POLY * WORDS),
  localparam int PW = (NUM_POLY > 1) ? $clog2(NUM_POLY) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    op_in,
  input  logic          swap_in,
  input  logic [PW-1:0] src_a,
  input  logic [PW-1:0] src_b,
  input  logic [PW-1:0] dst,
  input  logic          wb_valid,
  output logic [AW-1:0] raddr,
  output logic [AW-1:0] addr,
  output logic          valid,
  output logic          swap,
  output logic [1:0]    opcode,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int KW = $clog2(2 * WORDS);
  localparam int CW = $clog2(WORDS + 1);
  localparam int TW = $clog2(WB_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  state_t state;

  logic [KW-1:0] k;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [AW-1:0] base_a;
  logic [AW-1:0] base_b;
  logic [AW-1:0] base_d;

  logic [AW-1:0] a_in;
  logic [AW-1:0] b_in;
  logic [AW-1:0] d_in;
  logic          wb_hit;
  logic [CW-1:0] cnt_nx;
  logic [KW-1:0] k_nx;
  logic [AW-1:0] wi_nx;
  logic          last;
  logic [TW-1:0] tmo_inc;
  logic          tmo_hit;

  assign a_in = AW'(src_a) * AW'(WORDS);
  assign b_in = AW'(src_b) * AW'(WORDS);
  assign d_in = AW'(dst) * AW'(WORDS);

  // Strobes beyond a full polynomial are dropped so the count saturates.
  assign wb_hit = busy & wb_valid & (cnt < CW'(WORDS));
  assign cnt_nx = cnt + CW'(wb_hit);

  assign k_nx = k + 1'b1;
  assign wi_nx = AW'(k_nx >> 1);
  assign last = (k == KW'(2 * WORDS - 1));

  assign tmo_inc = tmo + 1'b1;
  assign tmo_hit = !wb_valid && (tmo_inc == TW'(WB_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      cnt    <= '0;
      tmo    <= '0;
      base_a <= '0;
      base_b <= '0;
      base_d <= '0;
      raddr  <= '0;
      addr   <= '0;
      valid  <= 1'b0;
      swap   <= 1'b0;
      opcode <= 2'd0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt    <= '0;
          tmo    <= '0;
          valid  <= 1'b0;
          busy   <= 1'b0;
          swap   <= 1'b0;
          opcode <= 2'd0;
          if (start) begin
            if (op_in == 2'd0) begin
              err <= 1'b1;
            end else begin
              state  <= ISSUE;
              busy   <= 1'b1;
              valid  <= 1'b1;
              opcode <= op_in;
              swap   <= swap_in;
              base_a <= a_in;
              base_b <= b_in;
              base_d <= d_in;
              raddr  <= a_in;
              addr   <= d_in;
              k      <= '0;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt_nx;
          tmo <= TW'(1);
          if (last) begin
            state <= DRAIN;
            valid <= 1'b0;
          end else begin
            k     <= k_nx;
            raddr <= (k_nx[0] ? base_b : base_a) + wi_nx;
            addr  <= base_d + wi_nx;
          end
        end
        DRAIN: begin
          cnt <= cnt_nx;
          if (cnt_nx == CW'(WORDS)) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (tmo_hit) begin
            state  <= IDLE;
            err    <= 1'b1;
            busy   <= 1'b0;
            swap   <= 1'b0;
            opcode <= 2'd0;
          end else begin
            tmo <= wb_valid ? TW'(1) : tmo_inc;
          end
        end
        FIN: begin
          state  <= IDLE;
          swap   <= 1'b0;
          opcode <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_arith_ctrl.sv
// Scoreboard bench for poly_arith_ctrl (LOGN=4, PE=2, NUM_POLY=4).
// Stimulus queues expected issue beats and done/err events; monitor pops.
module tb_poly_arith_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] op_in;
  logic       swap_in;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic [1:0] dst;
  logic       wb_valid = 1'b0;
  logic [3:0] raddr;
  logic [3:0] addr;
  logic       valid;
  logic       swap;
  logic [1:0] opcode;
  logic       busy;
  logic       done;
  logic       err;

  poly_arith_ctrl #(
    .LOGN(4),
    .PE(2),
    .NUM_POLY(4),
    .WB_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op_in(op_in),
    .swap_in(swap_in),
    .src_a(src_a),
    .src_b(src_b),
    .dst(dst),
    .wb_valid(wb_valid),
    .raddr(raddr),
    .addr(addr),
    .valid(valid),
    .swap(swap),
    .opcode(opcode),
    .busy(busy),
    .done(done),
    .err(err)
  );

  typedef struct {
    int         cyc;
    logic [3:0] ra;
    logic [3:0] ad;
    logic [1:0] op;
    logic       sw;
  } iss_t;

  typedef struct {
    int cyc;
    bit is_done;
  } evt_t;

  iss_t exp_issue[$];
  evt_t exp_evt[$];
  int   wb_q[$];

  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input bit ok,
                     input string act, input string req);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", nm, act, req);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask

  // Write-back model: strobe in each scheduled absolute cycle.
  initial forever begin
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    if (wb_q.size() > 0 && wb_q[0] == cyc) begin
      void'(wb_q.pop_front());
      wb_valid = 1'b1;
    end
  end

  // Monitor: every valid beat and every done/err pulse must be expected.
  initial forever begin
    iss_t e;
    evt_t v;
    @(negedge clk);
    if (valid === 1'b1) begin
      chk("valid_expected", exp_issue.size() > 0,
          $sformatf("valid raddr=%0d cyc=%0d", raddr, cyc), "no valid");
      if (exp_issue.size() > 0) begin
        e = exp_issue.pop_front();
        chk("issue_beat",
            cyc == e.cyc && raddr == e.ra && addr == e.ad &&
            opcode == e.op && swap == e.sw && busy === 1'b1,
            $sformatf("cyc=%0d raddr=%0d addr=%0d op=%0d sw=%0d busy=%0b",
                      cyc, raddr, addr, opcode, swap, busy),
            $sformatf("cyc=%0d raddr=%0d addr=%0d op=%0d sw=%0d busy=1",
                      e.cyc, e.ra, e.ad, e.op, e.sw));
      end
    end
    if (done === 1'b1 || err === 1'b1) begin
      chk("event_expected", exp_evt.size() > 0,
          $sformatf("done=%0b err=%0b cyc=%0d", done, err, cyc), "none");
      if (exp_evt.size() > 0) begin
        v = exp_evt.pop_front();
        chk(v.is_done ? "done_pulse" : "err_pulse",
            cyc == v.cyc && done == v.is_done && err == !v.is_done &&
            busy === 1'b0,
            $sformatf("cyc=%0d done=%0b err=%0b busy=%0b",
                      cyc, done, err, busy),
            $sformatf("cyc=%0d done=%0b err=%0b busy=0",
                      v.cyc, v.is_done, !v.is_done));
      end
    end
  end

  // ra/ad hold one hand-computed 4-bit address per nibble, k=0 in the top.
  task automatic push_run(input int c, input logic [1:0] op,
                          input logic sw, input logic [31:0] ra,
                          input logic [31:0] ad, input int n);
    for (int k = 0; k < n; k++) begin
      iss_t e;
      e.cyc = c + 1 + k;
      e.ra = ra[4*(7-k) +: 4];
      e.ad = ad[4*(7-k) +: 4];
      e.op = op;
      e.sw = sw;
      exp_issue.push_back(e);
    end
  endtask

  task automatic push_evt(input int t, input bit is_done);
    evt_t v;
    v.cyc = t;
    v.is_done = is_done;
    exp_evt.push_back(v);
  endtask

  task automatic drive_start(input logic [1:0] op, input logic sw,
                             input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] d);
    start = 1'b1;
    op_in = op;
    swap_in = sw;
    src_a = a;
    src_b = b;
    dst = d;
    tick(1);
    start = 1'b0;
    op_in = 2'd0;
    swap_in = ~sw;
    src_a = ~a;
    src_b = ~b;
    dst = ~d;
  endtask

  task automatic idle_zero(input string nm);
    @(negedge clk);
    chk(nm,
        {raddr, addr, opcode, valid, swap, busy, done, err} === 15'd0,
        $sformatf("ra=%0d ad=%0d op=%0d v=%0b sw=%0b b=%0b d=%0b e=%0b",
                  raddr, addr, opcode, valid, swap, busy, done, err),
        "all zero");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    rst = 1'b1;
    start = 1'b0;
    op_in = 2'd0;
    swap_in = 1'b0;
    src_a = 2'd0;
    src_b = 2'd0;
    dst = 2'd0;
    tick(3);
    idle_zero("reset_state");
    rst = 1'b0;
    tick(2);

    // Illegal op: err one cycle later, nothing else moves.
    c = cyc;
    push_evt(c + 1, 1'b0);
    drive_start(2'd0, 1'b0, 2'd1, 2'd2, 2'd3);
    @(negedge clk);
    chk("illegal_quiet",
        busy === 1'b0 && valid === 1'b0 && done === 1'b0 && raddr == 4'd0,
        $sformatf("busy=%0b valid=%0b done=%0b raddr=%0d",
                  busy, valid, done, raddr),
        "busy=0 valid=0 done=0 raddr=0");
    @(posedge clk);
    #1;
    tick(3);

    // Addition, write-backs with latency 6 after each pair.
    c = cyc;
    wb_q.push_back(c + 8);
    wb_q.push_back(c + 10);
    wb_q.push_back(c + 12);
    wb_q.push_back(c + 14);
    push_run(c, 2'd2, 1'b0, 32'h48596A7B, 32'hCCDDEEFF, 8);
    push_evt(c + 15, 1'b1);
    drive_start(2'd2, 1'b0, 2'd1, 2'd2, 2'd3);
    wait_until(c + 20);

    // Early write-backs: all inside ISSUE, done 2 cycles after last beat.
    c = cyc;
    wb_q.push_back(c + 2);
    wb_q.push_back(c + 3);
    wb_q.push_back(c + 5);
    wb_q.push_back(c + 7);
    push_run(c, 2'd3, 1'b1, 32'h0C1D2E3F, 32'h44556677, 8);
    push_evt(c + 10, 1'b1);
    drive_start(2'd3, 1'b1, 2'd0, 2'd3, 2'd1);
    wait_until(c + 14);

    // Timeout: only 3 write-backs, last at c+12 inside DRAIN.
    c = cyc;
    wb_q.push_back(c + 3);
    wb_q.push_back(c + 6);
    wb_q.push_back(c + 12);
    push_run(c, 2'd1, 1'b0, 32'h8495A6B7, 32'h00112233, 8);
    push_evt(c + 28, 1'b0);
    drive_start(2'd1, 1'b0, 2'd2, 2'd1, 2'd0);
    wait_until(c + 32);

    // Reset while k=3 is on the outputs.
    c = cyc;
    push_run(c, 2'd2, 1'b0, 32'h48596A7B, 32'hCCDDEEFF, 4);
    drive_start(2'd2, 1'b0, 2'd1, 2'd2, 2'd3);
    wait_until(c + 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    idle_zero("reset_mid_issue");
    tick(2);

    // In-place modmult on polynomial 0.
    c = cyc;
    wb_q.push_back(c + 4);
    wb_q.push_back(c + 6);
    wb_q.push_back(c + 8);
    wb_q.push_back(c + 10);
    push_run(c, 2'd1, 1'b0, 32'h00112233, 32'h00112233, 8);
    push_evt(c + 11, 1'b1);
    drive_start(2'd1, 1'b0, 2'd0, 2'd0, 2'd0);
    wait_until(c + 15);

    // Stray write-back in IDLE, then starts while busy and in FIN.
    c = cyc;
    wb_q.push_back(c + 1);
    tick(3);
    c = cyc;
    wb_q.push_back(c + 5);
    wb_q.push_back(c + 7);
    wb_q.push_back(c + 9);
    wb_q.push_back(c + 11);
    push_run(c, 2'd2, 1'b1, 32'hC0D1E2F3, 32'h8899AABB, 8);
    push_evt(c + 12, 1'b1);
    drive_start(2'd2, 1'b1, 2'd3, 2'd0, 2'd2);
    wait_until(c + 3);
    drive_start(2'd0, 1'b0, 2'd1, 2'd1, 2'd1);
    wait_until(c + 12);
    drive_start(2'd1, 1'b0, 2'd1, 2'd1, 2'd1);
    tick(20);

    chk("issue_drained", exp_issue.size() == 0,
        $sformatf("%0d beats left", exp_issue.size()), "0 beats left");
    chk("events_drained", exp_evt.size() == 0,
        $sformatf("%0d events left", exp_evt.size()), "0 events left");
    chk("wb_drained", wb_q.size() == 0,
        $sformatf("%0d strobes left", wb_q.size()), "0 strobes left");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
